// File: rtl/imem_arbiter_pkg.sv
// Shared widths, state encodings and defaults for the instruction-memory arbiter.
package imem_arbiter_pkg;

  localparam int unsigned ADDR_SIZE     = 15;
  localparam int unsigned INSTR_SIZE    = 31;
  localparam int unsigned IMARB_TIMEOUT = 16;

  typedef enum logic [1:0] {
    IMARB_IDLE = 2'd0,
    IMARB_BUSY = 2'd1,
    IMARB_RESP = 2'd2
  } imarb_state_e;

endpackage

// File: rtl/imem_rr_pick.sv
// Two-way round-robin picker: a lone request wins, a tie goes to the port not served last.
module imem_rr_pick (
  input  logic [1:0] req,
  input  logic       last,
  output logic       gnt_valid,
  output logic       gnt_idx
);

  always_comb begin
    gnt_valid = |req;
    gnt_idx   = 1'b0;
    case (req)
      2'b01:   gnt_idx = 1'b0;
      2'b10:   gnt_idx = 1'b1;
      2'b11:   gnt_idx = ~last;
      default: gnt_idx = 1'b0;
    endcase
  end

endmodule

// File: rtl/imem_arbiter.sv
// Shares the single imem read port between fetch (port 0) and debug/loader (port 1),
// one transaction in flight, with an optional cycle-count timeout.
module imem_arbiter
  import imem_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_W         = ADDR_SIZE + 1,
  parameter int unsigned DATA_W         = INSTR_SIZE + 1,
  parameter int unsigned TIMEOUT_CYCLES = IMARB_TIMEOUT
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] p0_rd_addr,
  input  logic              p0_rd_enable,
  output logic [DATA_W-1:0] p0_rd_data,
  output logic              p0_rd_ready,
  output logic              p0_rd_err,
  input  logic [ADDR_W-1:0] p1_rd_addr,
  input  logic              p1_rd_enable,
  output logic [DATA_W-1:0] p1_rd_data,
  output logic              p1_rd_ready,
  output logic              p1_rd_err,
  output logic [ADDR_W-1:0] mem_rd_addr,
  output logic              mem_rd_enable,
  input  logic [DATA_W-1:0] mem_rd_data,
  input  logic              mem_rd_ready,
  output logic              busy,
  output logic              grant
);

  // Counter only needs to reach TIMEOUT_CYCLES-1: the abort fires in the last BUSY cycle.
  localparam int unsigned CNT_W   = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam int unsigned TO_LAST = (TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0;
  localparam bit          TO_EN   = (TIMEOUT_CYCLES != 0);

  imarb_state_e             r_state, w_state_nxt;
  logic                     r_grant, w_grant_nxt;
  logic                     r_last, w_last_nxt;
  logic [ADDR_W-1:0]        r_addr, w_addr_nxt;
  logic [CNT_W-1:0]         r_cnt, w_cnt_nxt;
  logic [1:0][DATA_W-1:0]   r_data, w_data_nxt;
  logic [1:0]               r_err, w_err_nxt;
  logic [1:0]               r_rdy, w_rdy_nxt;
  logic                     r_mem_en, r_busy;
  logic                     w_gnt_valid, w_gnt_idx;
  logic                     w_timeout;

  imem_rr_pick u_pick (
    .req       ({p1_rd_enable, p0_rd_enable}),
    .last      (r_last),
    .gnt_valid (w_gnt_valid),
    .gnt_idx   (w_gnt_idx)
  );

  assign w_timeout = TO_EN && (r_cnt == CNT_W'(TO_LAST));

  // Next-state and response-register update
  always_comb begin
    w_state_nxt = r_state;
    w_grant_nxt = r_grant;
    w_last_nxt  = r_last;
    w_addr_nxt  = r_addr;
    w_cnt_nxt   = r_cnt;
    w_data_nxt  = r_data;
    w_err_nxt   = r_err;
    w_rdy_nxt   = 2'b00;
    case (r_state)
      IMARB_IDLE: begin
        if (w_gnt_valid) begin
          w_state_nxt = IMARB_BUSY;
          w_grant_nxt = w_gnt_idx;
          w_addr_nxt  = w_gnt_idx ? p1_rd_addr : p0_rd_addr;
          w_cnt_nxt   = '0;
        end
      end
      IMARB_BUSY: begin
        if (mem_rd_ready) begin
          w_data_nxt[r_grant] = mem_rd_data;
          w_err_nxt[r_grant]  = 1'b0;
          w_rdy_nxt[r_grant]  = 1'b1;
          w_state_nxt         = IMARB_RESP;
        end else if (w_timeout) begin
          w_data_nxt[r_grant] = '0;
          w_err_nxt[r_grant]  = 1'b1;
          w_rdy_nxt[r_grant]  = 1'b1;
          w_state_nxt         = IMARB_RESP;
        end else if (TO_EN) begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end
      IMARB_RESP: begin
        w_last_nxt  = r_grant;
        w_state_nxt = IMARB_IDLE;
      end
      default: w_state_nxt = IMARB_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state  <= IMARB_IDLE;
      r_grant  <= 1'b0;
      r_last   <= 1'b1;
      r_addr   <= '0;
      r_cnt    <= '0;
      r_data   <= '0;
      r_err    <= '0;
      r_rdy    <= '0;
      r_mem_en <= 1'b0;
      r_busy   <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_grant  <= w_grant_nxt;
      r_last   <= w_last_nxt;
      r_addr   <= w_addr_nxt;
      r_cnt    <= w_cnt_nxt;
      r_data   <= w_data_nxt;
      r_err    <= w_err_nxt;
      r_rdy    <= w_rdy_nxt;
      r_mem_en <= (w_state_nxt == IMARB_BUSY);
      r_busy   <= (w_state_nxt != IMARB_IDLE);
    end
  end

  assign p0_rd_data    = r_data[0];
  assign p0_rd_ready   = r_rdy[0];
  assign p0_rd_err     = r_err[0];
  assign p1_rd_data    = r_data[1];
  assign p1_rd_ready   = r_rdy[1];
  assign p1_rd_err     = r_err[1];
  assign mem_rd_addr   = r_addr;
  assign mem_rd_enable = r_mem_en;
  assign busy          = r_busy;
  assign grant         = r_grant;

endmodule

// File: tb/tb_imem_arbiter.sv
// Directed bench for imem_arbiter: scoreboard of expected completions plus cycle-exact checks.
module tb_imem_arbiter;

  typedef struct packed {
    logic        port;
    logic [31:0] data;
    logic        err;
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  // DUT with timeout 16
  logic [15:0] p0_rd_addr = '0, p1_rd_addr = '0;
  logic        p0_rd_enable = 1'b0, p1_rd_enable = 1'b0;
  logic [31:0] p0_rd_data, p1_rd_data;
  logic        p0_rd_ready, p1_rd_ready, p0_rd_err, p1_rd_err;
  logic [15:0] mem_rd_addr;
  logic        mem_rd_enable;
  logic [31:0] mem_rd_data = '0;
  logic        mem_rd_ready = 1'b0;
  logic        busy, grant;

  // DUT with timeout disabled
  logic [15:0] b_p0_rd_addr = '0, b_p1_rd_addr = '0;
  logic        b_p0_rd_enable = 1'b0, b_p1_rd_enable = 1'b0;
  logic [31:0] b_p0_rd_data, b_p1_rd_data;
  logic        b_p0_rd_ready, b_p1_rd_ready, b_p0_rd_err, b_p1_rd_err;
  logic [15:0] b_mem_rd_addr;
  logic        b_mem_rd_enable;
  logic [31:0] b_mem_rd_data = '0;
  logic        b_mem_rd_ready = 1'b0;
  logic        b_busy, b_grant;

  imem_arbiter #(.ADDR_W(16), .DATA_W(32), .TIMEOUT_CYCLES(16)) dut (
    .clk(clk), .reset(reset),
    .p0_rd_addr(p0_rd_addr), .p0_rd_enable(p0_rd_enable), .p0_rd_data(p0_rd_data),
    .p0_rd_ready(p0_rd_ready), .p0_rd_err(p0_rd_err),
    .p1_rd_addr(p1_rd_addr), .p1_rd_enable(p1_rd_enable), .p1_rd_data(p1_rd_data),
    .p1_rd_ready(p1_rd_ready), .p1_rd_err(p1_rd_err),
    .mem_rd_addr(mem_rd_addr), .mem_rd_enable(mem_rd_enable),
    .mem_rd_data(mem_rd_data), .mem_rd_ready(mem_rd_ready),
    .busy(busy), .grant(grant)
  );

  imem_arbiter #(.ADDR_W(16), .DATA_W(32), .TIMEOUT_CYCLES(0)) dut0 (
    .clk(clk), .reset(reset),
    .p0_rd_addr(b_p0_rd_addr), .p0_rd_enable(b_p0_rd_enable), .p0_rd_data(b_p0_rd_data),
    .p0_rd_ready(b_p0_rd_ready), .p0_rd_err(b_p0_rd_err),
    .p1_rd_addr(b_p1_rd_addr), .p1_rd_enable(b_p1_rd_enable), .p1_rd_data(b_p1_rd_data),
    .p1_rd_ready(b_p1_rd_ready), .p1_rd_err(b_p1_rd_err),
    .mem_rd_addr(b_mem_rd_addr), .mem_rd_enable(b_mem_rd_enable),
    .mem_rd_data(b_mem_rd_data), .mem_rd_ready(b_mem_rd_ready),
    .busy(b_busy), .grant(b_grant)
  );

  int   checks = 0;
  int   errors = 0;
  exp_t sb[$];

  int   mem_lat   = 1;
  logic mem_stall = 1'b0;
  logic mem_force = 1'b0;

  function automatic logic [31:0] mem_f(input logic [15:0] a);
    return (a == 16'h0010) ? 32'hDEADBEEF : {16'hA5A5, a};
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic port, input logic [31:0] data, input logic err);
    exp_t e;
    e.port = port;
    e.data = data;
    e.err  = err;
    sb.push_back(e);
  endtask

  task automatic wait_drain(input string tag);
    int n = 0;
    while ((busy || sb.size() != 0) && n < 60) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_busy"}, 64'(busy), 64'(0));
    chk({tag, "_sb"}, 64'(sb.size()), 64'(0));
  endtask

  // imem model: ready after mem_lat enabled cycles unless stalled; mem_force injects stray readies
  initial begin
    int mcnt = 0;
    forever begin
      @(negedge clk);
      if (!reset || !mem_rd_enable) begin
        mcnt = 0;
        mem_rd_ready = mem_force;
      end else begin
        mcnt++;
        mem_rd_ready = mem_force || (!mem_stall && mcnt >= mem_lat);
      end
      mem_rd_data = mem_f(mem_rd_addr);
    end
  end

  // Completion monitor: every rd_ready must match the head of the scoreboard
  initial begin
    logic prev0 = 1'b0, prev1 = 1'b0;
    exp_t e;
    forever begin
      @(negedge clk);
      if (reset) begin
        if (p0_rd_ready || p1_rd_ready) begin
          chk("one_port_ready", 64'(p0_rd_ready & p1_rd_ready), 64'(0));
          if (sb.size() == 0) begin
            chk("unexpected_ready", 64'({p1_rd_ready, p0_rd_ready}), 64'(0));
          end else begin
            e = sb.pop_front();
            chk("sb_port", 64'(p1_rd_ready), 64'(e.port));
            chk("sb_data", 64'(p1_rd_ready ? p1_rd_data : p0_rd_data), 64'(e.data));
            chk("sb_err", 64'(p1_rd_ready ? p1_rd_err : p0_rd_err), 64'(e.err));
          end
        end
        if (prev0) chk("p0_pulse_width", 64'(p0_rd_ready), 64'(0));
        if (prev1) chk("p1_pulse_width", 64'(p1_rd_ready), 64'(0));
      end
      prev0 = p0_rd_ready;
      prev1 = p1_rd_ready;
    end
  end

  initial begin
    logic got;
    logic exp_port [3] = '{1'b0, 1'b1, 1'b0};

    // Reset state
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("rst_outputs", 64'({p0_rd_ready, p1_rd_ready, p0_rd_err, p1_rd_err, mem_rd_enable, busy, grant}), 64'(0));
    chk("rst_data", 64'({p0_rd_data, p1_rd_data}), 64'(0));
    chk("rst_addr", 64'(mem_rd_addr), 64'(0));

    // Tie from reset: port 0, port 1, port 0
    p0_rd_addr = 16'h0004; p1_rd_addr = 16'h0008;
    p0_rd_enable = 1'b1;   p1_rd_enable = 1'b1;
    push(1'b0, mem_f(16'h0004), 1'b0);
    push(1'b1, mem_f(16'h0008), 1'b0);
    push(1'b0, mem_f(16'h0004), 1'b0);
    for (int k = 0; k < 3; k++) begin
      got = 1'b0;
      for (int c = 0; c < 20 && !got; c++) begin
        @(negedge clk);
        if (p0_rd_ready || p1_rd_ready) got = 1'b1;
      end
      chk("tie_done", 64'(got), 64'(1));
      chk("tie_grant", 64'(grant), 64'(exp_port[k]));
    end
    p0_rd_enable = 1'b0; p1_rd_enable = 1'b0;
    wait_drain("tie");

    // Port 0 alone, 1-cycle imem
    p0_rd_addr = 16'h0010; p0_rd_enable = 1'b1;
    push(1'b0, 32'hDEADBEEF, 1'b0);
    @(negedge clk);
    p0_rd_enable = 1'b0;
    chk("t1_addr", 64'(mem_rd_addr), 64'(16'h0010));
    chk("t1_mem_en", 64'({mem_rd_enable, busy, grant}), 64'(3'b110));
    @(negedge clk);
    chk("t1_ready", 64'({p0_rd_ready, p0_rd_err}), 64'(2'b10));
    chk("t1_data", 64'(p0_rd_data), 64'(32'hDEADBEEF));
    chk("t1_p1_quiet", 64'({p1_rd_ready, p1_rd_err}), 64'(0));
    @(negedge clk);
    chk("t1_after", 64'({p0_rd_ready, mem_rd_enable, busy}), 64'(0));
    wait_drain("t1");

    // Port 1 timeout at 0x20
    mem_stall = 1'b1;
    p1_rd_addr = 16'h0020; p1_rd_enable = 1'b1;
    push(1'b1, 32'h0, 1'b1);
    for (int i = 1; i <= 16; i++) begin
      @(negedge clk);
      if (i == 1) p1_rd_enable = 1'b0;
    end
    chk("to_not_yet", 64'({p1_rd_ready, busy}), 64'(2'b01));
    @(negedge clk);
    chk("to_ready", 64'({p1_rd_ready, p1_rd_err}), 64'(2'b11));
    chk("to_data", 64'(p1_rd_data), 64'(0));
    chk("to_p0_hold", 64'(p0_rd_data), 64'(32'hDEADBEEF));
    @(negedge clk);
    mem_force = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("late_ready_ignored", 64'({p0_rd_ready, p1_rd_ready, busy}), 64'(0));
    end
    mem_force = 1'b0;
    mem_stall = 1'b0;
    wait_drain("to");

    // Address/enable change during BUSY is ignored
    mem_lat = 3;
    p0_rd_addr = 16'h0010; p0_rd_enable = 1'b1;
    push(1'b0, 32'hDEADBEEF, 1'b0);
    @(negedge clk);
    p0_rd_enable = 1'b0; p0_rd_addr = 16'h0099;
    @(negedge clk);
    chk("hold_addr", 64'(mem_rd_addr), 64'(16'h0010));
    wait_drain("hold");
    mem_lat = 1;

    // Asynchronous reset mid-BUSY
    mem_stall = 1'b1;
    p0_rd_addr = 16'h0030; p0_rd_enable = 1'b1;
    @(negedge clk);
    p0_rd_enable = 1'b0;
    repeat (2) @(negedge clk);
    chk("mid_busy", 64'(busy), 64'(1));
    reset = 1'b0;
    #1;
    chk("arst_ctrl", 64'({mem_rd_enable, busy, grant, p0_rd_ready, p0_rd_err, p1_rd_err}), 64'(0));
    chk("arst_data", 64'({p0_rd_data, p1_rd_data}), 64'(0));
    chk("arst_addr", 64'(mem_rd_addr), 64'(0));
    repeat (2) @(negedge clk);
    reset = 1'b1;
    mem_stall = 1'b0;
    repeat (5) @(negedge clk);
    chk("arst_no_ready", 64'({p0_rd_ready, p1_rd_ready, busy}), 64'(0));
    p0_rd_addr = 16'h0004; p1_rd_addr = 16'h0008;
    p0_rd_enable = 1'b1;   p1_rd_enable = 1'b1;
    push(1'b0, mem_f(16'h0004), 1'b0);
    @(negedge clk);
    p0_rd_enable = 1'b0; p1_rd_enable = 1'b0;
    chk("arst_tie_grant", 64'(grant), 64'(0));
    wait_drain("arst");

    // Timeout disabled: 40-cycle stall completes without error
    b_p0_rd_addr = 16'h0044; b_p0_rd_enable = 1'b1;
    @(negedge clk);
    b_p0_rd_enable = 1'b0;
    chk("nto_issue", 64'({b_mem_rd_enable, b_mem_rd_addr}), 64'({1'b1, 16'h0044}));
    repeat (39) @(negedge clk);
    chk("nto_stalled", 64'({b_busy, b_p0_rd_ready}), 64'(2'b10));
    @(negedge clk);
    b_mem_rd_data = 32'h0BADF00D; b_mem_rd_ready = 1'b1;
    @(negedge clk);
    b_mem_rd_ready = 1'b0;
    chk("nto_ready", 64'({b_p0_rd_ready, b_p0_rd_err}), 64'(2'b10));
    chk("nto_data", 64'(b_p0_rd_data), 64'(32'h0BADF00D));
    @(negedge clk);
    chk("nto_idle", 64'({b_p0_rd_ready, b_busy}), 64'(0));

    repeat (2) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
